// File: rtl/vga_controlador.sv
// vga_controlador: VGA timing generator with raw counters, delayed sync/blank outputs and a frame counter
module vga_controlador #(
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int H_ATIVO = 640,
  parameter int H_FP    = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int V_ATIVO = 480,
  parameter int V_FP    = 10,
  parameter int ATRASO  = 1
) (
  input  logic        VGA_CLK,
  input  logic        reset,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  output logic        visivel,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        fim_quadro,
  output logic [15:0] contador_quadros
);
  localparam logic [9:0] H_B   = 10'(H_SYNC);
  localparam logic [9:0] H_A   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_F   = 10'(H_SYNC + H_BP + H_ATIVO);
  localparam logic [9:0] H_MAX = 10'(H_SYNC + H_BP + H_ATIVO + H_FP - 1);
  localparam logic [9:0] V_B   = 10'(V_SYNC);
  localparam logic [9:0] V_A   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_F   = 10'(V_SYNC + V_BP + V_ATIVO);
  localparam logic [9:0] V_MAX = 10'(V_SYNC + V_BP + V_ATIVO + V_FP - 1);
  typedef enum logic [1:0] {SYNC, BACK, ATIVO, FRONT} fase_t;
  fase_t h_q, h_d, v_q, v_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic vis_q, vis_d, fim_q, fim_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ATRASO-1:0] hs_q, hs_d, vs_q, vs_d, bl_q, bl_d;
  always_ff @(posedge VGA_CLK or negedge reset)
    if (!reset) begin
      x_q   <= '0;
      y_q   <= '0;
      h_q   <= SYNC;
      v_q   <= SYNC;
      vis_q <= 1'b0;
      fim_q <= 1'b0;
      cnt_q <= '0;
      hs_q  <= '1;
      vs_q  <= '1;
      bl_q  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      h_q   <= h_d;
      v_q   <= v_d;
      vis_q <= vis_d;
      fim_q <= fim_d;
      cnt_q <= cnt_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      bl_q  <= bl_d;
    end
  always_comb begin
    x_d = (x_q == H_MAX) ? '0 : x_q + 10'd1;
    y_d = (x_q != H_MAX) ? y_q : (y_q == V_MAX) ? '0 : y_q + 10'd1;
    h_d = (x_d == '0)  ? SYNC :
          (x_d == H_B) ? BACK :
          (x_d == H_A) ? ATIVO :
          (x_d == H_F) ? FRONT : h_q;
    v_d = (x_q != H_MAX) ? v_q :
          (y_d == '0)    ? SYNC :
          (y_d == V_B)   ? BACK :
          (y_d == V_A)   ? ATIVO :
          (y_d == V_F)   ? FRONT : v_q;
  end
  always_comb begin
    vis_d = (h_d == ATIVO) && (v_d == ATIVO);
    fim_d = (x_d == '0) && (y_d == V_F);
    cnt_d = cnt_q + 16'(fim_q);
    hs_d  = ATRASO'({hs_q, h_q != SYNC});
    vs_d  = ATRASO'({vs_q, v_q != SYNC});
    bl_d  = ATRASO'({bl_q, vis_q});
  end
  assign VGA_X            = x_q;
  assign VGA_Y            = y_q;
  assign visivel          = vis_q;
  assign fim_quadro       = fim_q;
  assign contador_quadros = cnt_q;
  assign VGA_HS           = hs_q[ATRASO-1];
  assign VGA_VS           = vs_q[ATRASO-1];
  assign VGA_BLANK_N      = bl_q[ATRASO-1];
  assign VGA_SYNC_N       = 1'b0;
endmodule

// File: doc/vga_controlador.md
VGA_CONTROLADOR -- requirements
Module: vga_controlador

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, hsync pulse width in pixels.
REQ-002 SHALL have parameters H_BP=48, H_ATIVO=640, H_FP=16; H_TOTAL = sum = 800.
REQ-003 SHALL have parameters V_SYNC=2, V_BP=33, V_ATIVO=480, V_FP=10; V_TOTAL = sum = 525.
REQ-004 SHALL have parameter ATRASO, default 1, range 1..4, pipeline delay from counters to sync/blank outputs (matches downstream pixel-colour register stage).
REQ-005 VGA_CLK  input  1  pixel clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 VGA_X  output  10  raw horizontal counter, 0..H_TOTAL-1; visible pixels at 144..783.
REQ-008 VGA_Y  output  10  raw vertical counter, 0..V_TOTAL-1; visible lines at 35..514.
REQ-009 visivel  output  1  high when current VGA_X/VGA_Y lie in visible region, aligned with counters.
REQ-010 VGA_HS  output  1  hsync, active-low, delayed ATRASO cycles.
REQ-011 VGA_VS  output  1  vsync, active-low, delayed ATRASO cycles.
REQ-012 VGA_BLANK_N  output  1  visivel delayed ATRASO cycles.
REQ-013 VGA_SYNC_N  output  1  constant 0.
REQ-014 fim_quadro  output  1  one-cycle pulse per frame marking start of vertical front porch, for game-state update.
REQ-015 contador_quadros  output  16  frames completed since reset.

Function
REQ-016 VGA_X SHALL increment by 1 each cycle; at H_TOTAL-1 it SHALL wrap to 0 next cycle.
REQ-017 VGA_Y SHALL increment only in the cycle VGA_X wraps; at VGA_X=H_TOTAL-1 and VGA_Y=V_TOTAL-1 both SHALL wrap to 0 together.
REQ-018 Horizontal phase SHALL be tracked as states SYNC (X 0..95), BACK (96..143), ATIVO (144..783), FRONT (784..799); vertical likewise with SYNC (0..1), BACK (2..34), ATIVO (35..514), FRONT (515..524).
REQ-019 Undelayed hsync SHALL be 0 exactly while VGA_X < H_SYNC; undelayed vsync SHALL be 0 exactly while VGA_Y < V_SYNC (whole lines, not pixel-offset).
REQ-020 visivel SHALL be 1 iff horizontal state=ATIVO and vertical state=ATIVO.
REQ-021 VGA_HS, VGA_VS, VGA_BLANK_N SHALL equal undelayed hsync, vsync, visivel from exactly ATRASO cycles earlier, via a shift-register pipeline; no combinational path from counters.
REQ-022 fim_quadro SHALL be 1 exactly in the cycle where VGA_X=0 and VGA_Y=515, and 0 otherwise.
REQ-023 contador_quadros SHALL increment in the same cycle fim_quadro is 1, becoming visible next cycle; 65535 SHALL wrap to 0.
REQ-024 Counter arithmetic SHALL be unsigned 10-bit; no value outside 0..H_TOTAL-1 / 0..V_TOTAL-1 SHALL ever appear.
REQ-025 All outputs SHALL be registered and glitch-free.

Reset
REQ-026 While reset=0: VGA_X=0, VGA_Y=0, visivel=0, fim_quadro=0, contador_quadros=0, and every pipeline stage SHALL hold inactive values (VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0).
REQ-027 First rising edge after reset deasserts SHALL yield VGA_X=1, VGA_Y=0; pipeline outputs SHALL show sync values starting ATRASO cycles after release.
REQ-028 Reset asserted mid-frame SHALL take effect immediately (asynchronously), discarding pipeline contents and frame count.

Verification
REQ-029 Release reset, run 800 cycles, ATRASO=1 -> VGA_X sequence 1..799,0; VGA_Y steps 0->1 at wrap; VGA_HS=0 for exactly 96 cycles starting cycle 2 after release.
REQ-030 Run one full frame (420000 cycles) -> VGA_VS low for exactly 1600 cycles; VGA_BLANK_N high for exactly 307200 cycles; VGA_Y wraps 524->0 with VGA_X 799->0.
REQ-031 Check alignment -> at VGA_X=144,VGA_Y=35 visivel=1; VGA_BLANK_N rises exactly ATRASO cycles later; at VGA_X=784 visivel=0.
REQ-032 Run 3 frames -> fim_quadro pulses 3 times, 420000 cycles apart, each at (0,515); contador_quadros 0->1->2->3.
REQ-033 Assert reset at VGA_X=400,VGA_Y=200 with ATRASO=4 -> all outputs reach REQ-026 values without clock edge; after release VGA_HS stays 1 for 4 cycles, then 0.
REQ-034 Force contador_quadros to 65535 via long run or backdoor, next frame -> value 0, fim_quadro still single-cycle.
